// File: rtl/result_streamer_if.sv
// result_streamer_if : valid/ready word stream carrying big-endian result words.
`default_nettype none

interface result_streamer_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/result_streamer.sv
// result_streamer : on a done rising edge, reads the M x N2 result matrix byte-wise from data memory
// and streams big-endian 32-bit words; optional macro STATS_EN prepends a {clock_count, instr_cnt} header.
`default_nettype none

module result_streamer #(
  parameter int M      = 3,
  parameter int N      = 4,
  parameter int N2     = 1,
  parameter int ADDR_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              done,
  input  logic [15:0]       clock_count,
  input  logic [15:0]       instr_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  result_streamer_if.master o_stream,
  output logic              busy,
  output logic              finished
);

  localparam int RES_BASE = 4 * (M * N + N * N2);
  localparam int WORDS    = M * N2;
  localparam int WIDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_HOLD     = 2'd2,
    S_FINISHED = 2'd3
  } state_t;

  state_t              r_state;
  logic [WIDX_W-1:0]   r_widx;
  logic [2:0]          r_cnt;
  logic [23:0]         r_acc;
  logic                r_done_q;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_valid;
  logic [31:0]         r_data;
  logic                r_last;
  logic                r_busy;
  logic                r_finished;
`ifdef STATS_EN
  logic                r_hdr;
`else
  logic                w_unused_stats;
  assign w_unused_stats = ^{clock_count, instr_cnt};
`endif

  logic w_trigger;
  logic w_handshake;
  logic w_last_word;

  assign w_trigger   = done & ~r_done_q;
  assign w_handshake = r_valid & o_stream.out_ready;
  assign w_last_word = (r_widx == LAST_WIDX);

  function automatic logic [ADDR_W-1:0] addr_of(input logic [WIDX_W-1:0] w, input logic [1:0] b);
    return ADDR_W'(RES_BASE) + (ADDR_W'(w) << 2) + ADDR_W'(b);
  endfunction

  // r_cnt counts edges spent in FETCH: addresses go out on counts 0..2 (offset cnt+1),
  // bytes come back one edge behind the address and are captured on counts 1..4.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_widx     <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_done_q   <= 1'b0;
      r_mem_addr <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
`ifdef STATS_EN
      r_hdr      <= 1'b0;
`endif
    end else begin
      r_done_q <= done;
      case (r_state)
        S_IDLE, S_FINISHED: begin
          if (w_trigger) begin
            r_busy     <= 1'b1;
            r_finished <= 1'b0;
            r_widx     <= '0;
            r_cnt      <= '0;
            r_mem_addr <= addr_of('0, 2'd0);
`ifdef STATS_EN
            r_data     <= {clock_count, instr_cnt};
            r_valid    <= 1'b1;
            r_last     <= 1'b0;
            r_hdr      <= 1'b1;
            r_state    <= S_HOLD;
`else
            r_state    <= S_FETCH;
`endif
          end
        end

        S_FETCH: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt < 3'd3) begin
            r_mem_addr <= addr_of(r_widx, 2'(r_cnt + 3'd1));
          end
          if (r_cnt != 3'd0) begin
            r_acc <= {r_acc[15:0], mem_rdata};
          end
          if (r_cnt == 3'd4) begin
            r_data  <= {r_acc, mem_rdata};
            r_valid <= 1'b1;
            r_last  <= w_last_word;
            r_state <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (w_handshake) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
`ifdef STATS_EN
            if (r_hdr) begin
              r_hdr      <= 1'b0;
              r_cnt      <= '0;
              r_mem_addr <= addr_of('0, 2'd0);
              r_state    <= S_FETCH;
            end else
`endif
            if (!w_last_word) begin
              r_widx     <= r_widx + 1'b1;
              r_cnt      <= '0;
              r_mem_addr <= addr_of(r_widx + 1'b1, 2'd0);
              r_state    <= S_FETCH;
            end else begin
              r_busy     <= 1'b0;
              r_finished <= 1'b1;
              r_state    <= S_FINISHED;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr           = r_mem_addr;
  assign o_stream.out_valid = r_valid;
  assign o_stream.out_data  = r_data;
  assign o_stream.out_last  = r_last;
  assign busy               = r_busy;
  assign finished           = r_finished;

endmodule

`default_nettype wire

// File: tb/tb_result_streamer.sv
// tb_result_streamer : directed table-driven bench for result_streamer (default and M=2,N=2,N2=2 instances).
`timescale 1ns/1ps
`default_nettype none

module tb_result_streamer;

`ifdef STATS_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        done1 = 1'b0, done2 = 1'b0;
  logic        ready1 = 1'b1, ready2 = 1'b1;
  logic [15:0] cc = 16'h0123;
  logic [15:0] ic = 16'h0045;
  logic [7:0]  addr1, addr2;
  logic [7:0]  rdata1 = 8'h00, rdata2 = 8'h00;
  logic        busy1, fin1, busy2, fin2;
  logic [7:0]  mem1 [256];
  logic [7:0]  mem2 [256];

  int n_cmp = 0;
  int n_bad = 0;

  result_streamer_if s1 ();
  result_streamer_if s2 ();
  assign s1.out_ready = ready1;
  assign s2.out_ready = ready2;

  result_streamer #(.M(3), .N(4), .N2(1), .ADDR_W(8)) u_dut1 (
    .CLOCK_50(clk), .reset(rst), .done(done1), .clock_count(cc), .instr_cnt(ic),
    .mem_addr(addr1), .mem_rdata(rdata1), .o_stream(s1.master), .busy(busy1), .finished(fin1)
  );

  result_streamer #(.M(2), .N(2), .N2(2), .ADDR_W(8)) u_dut2 (
    .CLOCK_50(clk), .reset(rst), .done(done2), .clock_count(cc), .instr_cnt(ic),
    .mem_addr(addr2), .mem_rdata(rdata2), .o_stream(s2.master), .busy(busy2), .finished(fin2)
  );

  always @(posedge clk) begin
    rdata1 <= mem1[addr1];
    rdata2 <= mem2[addr2];
  end

  function automatic logic vld(input int which);
    return (which == 1) ? s1.out_valid : s2.out_valid;
  endfunction
  function automatic logic [31:0] dat(input int which);
    return (which == 1) ? s1.out_data : s2.out_data;
  endfunction
  function automatic logic lst(input int which);
    return (which == 1) ? s1.out_last : s2.out_last;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Waits (bounded) for out_valid, then checks the word without consuming it.
  task automatic wait_word(input int which, input string name, input vec_t e, output int c);
    c = 0;
    while (!vld(which) && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    if (!vld(which)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: out_valid never rose within %0d cycles", name, c);
    end else begin
      check({name, " data"}, 64'(dat(which)), 64'(e.data));
      check({name, " last"}, 64'(lst(which)), 64'(e.last));
    end
  endtask

  task automatic get_word(input int which, input string name, input vec_t e, output int c);
    wait_word(which, name, e, c);
    @(posedge clk); #1;
  endtask

  task automatic trigger1(input logic pulse);
    @(negedge clk); done1 = 1'b1;
    @(posedge clk); #1;
    if (pulse) done1 = 1'b0;
  endtask

  vec_t t1[$];
  vec_t t2[$];

  initial begin
    int c;
    int bad;
    logic [31:0] hd;
    logic        hl;
    logic [7:0]  ha;

    for (int k = 0; k < 256; k++) begin
      mem1[k] = 8'(k) ^ 8'hA5;
      mem2[k] = 8'(k) ^ 8'h3C;
    end
    mem1[64] = 8'h00; mem1[65] = 8'h00; mem1[66] = 8'h00; mem1[67] = 8'h1E;
    mem1[68] = 8'h00; mem1[69] = 8'h00; mem1[70] = 8'h00; mem1[71] = 8'h46;
    mem1[72] = 8'hFF; mem1[73] = 8'hFF; mem1[74] = 8'hFF; mem1[75] = 8'hF6;
    for (int k = 0; k < 16; k++) mem2[32 + k] = 8'hA0 + 8'(k);

`ifdef STATS_EN
    t1.push_back({32'h01230045, 1'b0});
    t2.push_back({32'h01230045, 1'b0});
`endif
    t1.push_back({32'h0000001E, 1'b0});
    t1.push_back({32'h00000046, 1'b0});
    t1.push_back({32'hFFFFFFF6, 1'b1});
    t2.push_back({32'hA0A1A2A3, 1'b0});
    t2.push_back({32'hA4A5A6A7, 1'b0});
    t2.push_back({32'hA8A9AAAB, 1'b0});
    t2.push_back({32'hACADAEAF, 1'b1});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset mem_addr", 64'(addr1), 64'h0);
    check("reset out_valid", 64'(s1.out_valid), 64'h0);
    check("reset out_data", 64'(s1.out_data), 64'h0);
    check("reset busy/finished/last", 64'({busy1, fin1, s1.out_last}), 64'h0);
    @(negedge clk); rst = 1'b0;

    // Basic stream with latency check
    trigger1(1'b1);
    check("trigger busy", 64'(busy1), 64'h1);
    check("trigger mem_addr", 64'(addr1), 64'd64);
    check("trigger finished", 64'(fin1), 64'h0);
    for (int i = 0; i < t1.size(); i++) begin
      get_word(1, $sformatf("basic w%0d", i), t1[i], c);
      if (i == H) check("first word latency", 64'(c), 64'd5);
    end
    check("basic finished", 64'({fin1, busy1, s1.out_valid}), 64'b100);

    // Backpressure on word 1
    ready1 = 1'b0;
    trigger1(1'b1);
    for (int i = 0; i < t1.size(); i++) begin
      wait_word(1, $sformatf("bp w%0d", i), t1[i], c);
      if (i == 1) begin
        hd = s1.out_data; hl = s1.out_last; ha = addr1;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); #1;
          check($sformatf("bp stall %0d", k), {23'h0, s1.out_valid, hd, hl, ha},
                {23'h0, 1'b1, t1[1].data, t1[1].last, ha});
        end
        check("bp stall addr", 64'(addr1), 64'(ha));
        check("bp stall data", 64'({s1.out_data, s1.out_last}), 64'({hd, hl}));
      end
      ready1 = 1'b1;
      @(posedge clk); #1;
      ready1 = 1'b0;
    end
    check("bp finished", 64'({fin1, busy1}), 64'b10);
    ready1 = 1'b1;

    // done held high: one run, then no retrigger
    trigger1(1'b0);
    for (int i = 0; i < t1.size(); i++) get_word(1, $sformatf("hold w%0d", i), t1[i], c);
    bad = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (s1.out_valid || !fin1 || busy1) bad++;
    end
    check("no retrigger while done high", 64'(bad), 64'h0);
    @(negedge clk); done1 = 1'b0;
    trigger1(1'b1);
    for (int i = 0; i < t1.size(); i++) get_word(1, $sformatf("rerun w%0d", i), t1[i], c);
    check("rerun finished", 64'(fin1), 64'h1);

    // Reset mid-fetch at RES_BASE+5
    trigger1(1'b1);
    get_word(1, "abort w0", t1[0], c);
    c = 0;
    while (addr1 != 8'd69 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check("abort reached addr 69", 64'(addr1), 64'd69);
    rst = 1'b1;
    #1;
    check("abort async clear", {23'h0, addr1, s1.out_valid, s1.out_data, s1.out_last, busy1, fin1}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (s1.out_valid || busy1 || fin1) bad++;
    end
    check("abort stays idle", 64'(bad), 64'h0);
    trigger1(1'b1);
    get_word(1, "after abort w0", t1[0], c);

    // Second parameterisation: M=2,N=2,N2=2, RES_BASE=32
    @(negedge clk); done2 = 1'b1;
    @(posedge clk); #1;
    done2 = 1'b0;
    check("dut2 trigger addr", 64'(addr2), 64'd32);
    for (int i = 0; i < t2.size(); i++) get_word(2, $sformatf("dut2 w%0d", i), t2[i], c);
    check("dut2 finished", 64'({fin2, busy2}), 64'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/result_streamer.md
Name: result_streamer

Overview:
- Downstream consumer of the RISCV CPU.
- On the CPU's `done` rising edge, reads the result matrix (M x N2 words) out of data memory through a byte-wide synchronous read port.
- Assembles each group of 4 bytes big-endian into a 32-bit word and streams the words out on a valid/ready interface.
- Feeds the FPGA host/UART path and the bench scoreboard, replacing hierarchical peeks into data memory.

Parameters:
- M, 3, rows of matrix1 / rows of result
- N, 4, cols of matrix1 / rows of matrix2
- N2, 1, cols of matrix2 / cols of result
- ADDR_W, 8, data-memory byte-address width; must satisfy 2^ADDR_W >= 4*(M*N+N*N2+M*N2)
- Derived localparam RES_BASE = 4*(M*N+N*N2), the first result byte address (64 at defaults).

Ports:
- CLOCK_50  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- done  in  1  CPU program-complete level
- clock_count  in  16  CPU cycle count, valid while done=1
- instr_cnt  in  16  CPU retired-instruction count, valid while done=1
- mem_addr  out  ADDR_W  data-memory byte read address
- mem_rdata  in  8  byte at the mem_addr presented on the previous cycle (1-cycle synchronous read)
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts the word
- out_data  out  32  result word, big-endian assembled
- out_last  out  1  high with the final word
- busy  out  1  high from trigger until the last handshake
- finished  out  1  high after the last word is accepted, until re-trigger or reset

Behaviour:
- Reset (async): state IDLE; mem_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, finished=0; word index=0; done-edge register cleared to 0.
- Trigger: the rising edge that samples done=1 with the previous sample 0.
  - Accepted in IDLE and FINISHED only.
  - Ignored in FETCH and HOLD.
  - done held high never retriggers.
- FSM states: IDLE, FETCH, HOLD, FINISHED.
- IDLE -> FETCH on trigger. The trigger edge sets busy=1, finished=0, word index=0, byte index=0, and drives mem_addr=RES_BASE.
- FETCH:
  - mem_addr = RES_BASE + 4*widx + bidx, with bidx stepping 0..3 on consecutive cycles.
  - Each returning byte is shifted into the low byte of an accumulator one edge later; the first byte ends up in bits 31:24.
  - Once the 4th byte is captured, go to HOLD with out_valid=1.
  - Latency: out_valid is high after the 5th rising edge following the edge that entered FETCH.
- HOLD:
  - out_data, out_last and out_valid are held stable while out_ready=0.
  - Handshake is out_valid&&out_ready at a rising edge; on it out_valid drops.
  - If widx < M*N2-1: widx+1, go to FETCH.
  - Otherwise go to FINISHED with busy=0, finished=1.
- out_last = out_valid && (widx == M*N2-1).
- mem_addr holds its last value outside FETCH.
- Word order is row-major: result[i][j] at byte RES_BASE + 4*(i*N2+j).
- Reset asserted mid-FETCH or mid-HOLD aborts immediately; no partial word is emitted after reset deasserts.
- FINISHED -> FETCH on a new trigger; the sequence restarts from widx=0.
- out_data width rule: no sign handling; the bytes are concatenated verbatim.

Optional Feature:
- Macro STATS_EN.
- When defined:
  - A header word {clock_count, instr_cnt} is emitted before the first result word.
  - It is captured on the trigger edge, and the FSM enters HOLD directly with out_valid=1 on the next cycle.
  - After it is accepted, the FSM goes to FETCH for widx=0.
  - out_last is never set on the header.
  - Total words emitted = M*N2+1.
- When undefined: no header, no capture registers; exactly M*N2 words.

Test Plan:
1. Memory bytes 64..75 = 00 00 00 1E / 00 00 00 46 / FF FF FF F6, out_ready=1, done pulse -> words 0x0000001E, 0x00000046, 0xFFFFFFF6; out_last only on the third; first out_valid 5 edges after the trigger edge; finished=1 afterwards.
2. Backpressure: out_ready=0 for 10 cycles during word 1 -> out_valid/out_data/out_last stay constant; no mem_addr change; output completes after out_ready=1.
3. done held high for 200 cycles after completion -> no retrigger, finished stays 1; done low then high -> identical 3-word sequence repeats.
4. reset asserted while mem_addr=RES_BASE+5 -> all outputs zero in the same cycle; no out_valid until a new done edge.
5. STATS_EN, clock_count=0x0123, instr_cnt=0x0045 -> first word 0x01230045 with out_last=0, then the 3 words of test 1.
6. Parameters M=2,N=2,N2=2 (RES_BASE=32), bytes 32..47 preloaded -> 4 words from addresses 32,36,40,44 in order; out_last on the 4th.
